// File: rtl/neur_access_sched.sv
// Neuron-memory access scheduler.
// Shares the single-port neuron state memory and the neuron update logic
// between synaptic/virtual events and the time-reference (leak) sweep. Every
// grant is an atomic read cycle followed by a write cycle. The scheduler only
// takes a new decision when it is idle or in a write cycle.
module neur_access_sched #(
    parameter int N = 256,
    parameter int M = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         SPI_GATE_ACTIVITY_sync,
    input  logic         EVT_REQ,
    input  logic [M-1:0] EVT_NEUR_ADDR,
    input  logic [4:0]   EVT_VIRTS,
    output logic         EVT_ACK,
    input  logic         TREF_REQ,
    output logic         TREF_OVF,
    output logic         SWEEP_DONE,
    output logic         BUSY,
    output logic         CTRL_NEURMEM_CS,
    output logic         CTRL_NEURMEM_WE,
    output logic [M-1:0] CTRL_NEURMEM_ADDR,
    output logic         CTRL_NEUR_EVENT,
    output logic         CTRL_NEUR_TREF,
    output logic [4:0]   CTRL_NEUR_VIRTS
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    // N is a power of two, so the M-bit counter wraps modulo N naturally.
    localparam logic [M-1:0] LAST_NEUR = M'(N - 1);

    state_t       state_q, state_d;
    logic [M-1:0] addr_q, addr_d;
    logic         is_evt_q, is_evt_d;
    logic         is_tref_q, is_tref_d;
    logic [4:0]   virts_q, virts_d;
    logic         sweep_active_q, sweep_active_d;
    logic         sweep_pend_q, sweep_pend_d;
    logic [M-1:0] sweep_cnt_q, sweep_cnt_d;
    logic         last_tref_q, last_tref_d;

    logic         sweep_wr;
    logic         sweep_end;
    logic         evt_elig;
    logic         sweep_elig;
    logic         pick_tref;
    logic         ovf;

    // State registers; reset aborts any access in flight and drops all work.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            is_evt_q       <= 1'b0;
            is_tref_q      <= 1'b0;
            virts_q        <= '0;
            sweep_active_q <= 1'b0;
            sweep_pend_q   <= 1'b0;
            sweep_cnt_q    <= '0;
            last_tref_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            is_evt_q       <= is_evt_d;
            is_tref_q      <= is_tref_d;
            virts_q        <= virts_d;
            sweep_active_q <= sweep_active_d;
            sweep_pend_q   <= sweep_pend_d;
            sweep_cnt_q    <= sweep_cnt_d;
            last_tref_q    <= last_tref_d;
        end
    end

    // Sweep bookkeeping, arbitration and next-state selection.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        is_evt_d       = is_evt_q;
        is_tref_d      = is_tref_q;
        virts_d        = virts_q;
        sweep_active_d = sweep_active_q;
        sweep_pend_d   = sweep_pend_q;
        sweep_cnt_d    = sweep_cnt_q;
        last_tref_d    = last_tref_q;
        ovf            = 1'b0;
        pick_tref      = 1'b0;

        sweep_wr  = (state_q == S_WR) && is_tref_q;
        sweep_end = sweep_wr && (sweep_cnt_q == LAST_NEUR);

        if (sweep_wr) begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
        end

        // The last write of a sweep hands over to the pending sweep (or a
        // request arriving right now); a pend+req collision keeps one pending.
        if (sweep_end) begin
            sweep_active_d = sweep_pend_q | TREF_REQ;
            sweep_pend_d   = sweep_pend_q & TREF_REQ;
        end else if (TREF_REQ) begin
            if (!sweep_active_q) begin
                sweep_active_d = 1'b1;
                sweep_cnt_d    = '0;
            end else if (!sweep_pend_q) begin
                sweep_pend_d = 1'b1;
            end else begin
                ovf = 1'b1;
            end
        end

        // The write cycle of an ack must not regrant the request being acked.
        evt_elig   = EVT_REQ && !((state_q == S_WR) && is_evt_q);
        sweep_elig = sweep_active_d;

        case (state_q)
            S_RD: begin
                state_d = S_WR;
            end
            default: begin
                if (!SPI_GATE_ACTIVITY_sync && (evt_elig || sweep_elig)) begin
                    pick_tref   = sweep_elig && (!evt_elig || !last_tref_q);
                    state_d     = S_RD;
                    last_tref_d = pick_tref;
                    if (pick_tref) begin
                        addr_d    = sweep_cnt_d;
                        is_evt_d  = 1'b0;
                        is_tref_d = 1'b1;
                        virts_d   = '0;
                    end else begin
                        addr_d    = EVT_NEUR_ADDR;
                        is_evt_d  = 1'b1;
                        is_tref_d = 1'b0;
                        virts_d   = EVT_VIRTS;
                    end
                end else begin
                    state_d   = S_IDLE;
                    is_evt_d  = 1'b0;
                    is_tref_d = 1'b0;
                    virts_d   = '0;
                end
            end
        endcase
    end

    assign CTRL_NEURMEM_CS   = (state_q != S_IDLE);
    assign CTRL_NEURMEM_WE   = (state_q == S_WR);
    assign CTRL_NEURMEM_ADDR = addr_q;
    assign CTRL_NEUR_EVENT   = is_evt_q;
    assign CTRL_NEUR_TREF    = is_tref_q;
    assign CTRL_NEUR_VIRTS   = virts_q;
    assign EVT_ACK           = (state_q == S_WR) && is_evt_q;
    assign SWEEP_DONE        = sweep_end;
    assign TREF_OVF          = ovf;
    assign BUSY              = (state_q != S_IDLE) || sweep_active_q;

endmodule
